// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: byte/half/word loads and stores over a
// valid/ready request port, driving a word-wide synchronous RAM port.
module dmem_access_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, RESP} state_t;

  state_t            state;
  state_t            next_state;
  logic              lat_write;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [ADDR_W+1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       rd_reg;

  logic              accept;
  logic              req_err;
  logic              word_store;
  logic [4:0]        lane_shift;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;
  logic [31:0]       merged;
  logic              unused_addr_bits;

  // Address bits above the RAM range are dropped, so accesses wrap.
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign accept     = req_valid && (state == IDLE);
  assign req_err    = (req_size == 2'b11) ||
                      ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign word_store = lat_write && (lat_size == SZ_WORD);
  assign lane_shift = {lat_addr[1:0], 3'b000};

  always_comb begin
    byte_sel = 8'(mem_rdata >> lane_shift);
    half_sel = 16'(mem_rdata >> {lat_addr[1], 4'b0000});
    load_ext = mem_rdata;
    case (lat_size)
      SZ_BYTE: load_ext = lat_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = lat_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Replace only the addressed lane of the word read back from RAM.
  always_comb begin
    merged = rd_reg;
    if (lat_size == SZ_BYTE)
      merged = (rd_reg & ~(32'h0000_00FF << lane_shift)) |
               ({24'h0, lat_wdata[7:0]} << lane_shift);
    else if (lat_size == SZ_HALF)
      merged = (rd_reg & ~(32'h0000_FFFF << {lat_addr[1], 4'b0000})) |
               ({16'h0, lat_wdata[15:0]} << {lat_addr[1], 4'b0000});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_write    <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= 32'h0;
      rd_reg       <= 32'h0;
      resp_err     <= 1'b0;
      resp_rdata   <= 32'h0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_write    <= req_write;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_addr     <= req_addr[ADDR_W+1:0];
        lat_wdata    <= req_wdata;
      end
      case (state)
        IDLE: begin
          if (accept && req_err) begin
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
          end
        end
        ISSUE: begin
          if (word_store) begin
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
          end
        end
        WAIT: begin
          rd_reg <= mem_rdata;
          if (!lat_write) begin
            resp_err   <= 1'b0;
            resp_rdata <= load_ext;
          end
        end
        WRITE: begin
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = req_err ? RESP : ISSUE;
      ISSUE:   next_state = word_store ? RESP : WAIT;
      WAIT:    next_state = lat_write ? WRITE : RESP;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM port is decoded purely from state and the latched request.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_addr   = lat_addr[ADDR_W+1:2];
    mem_we     = ((state == ISSUE) && word_store) || (state == WRITE);
    mem_wdata  = (state == WRITE) ? merged : lat_wdata;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl with a behavioural
// synchronous RAM attached to the memory port.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:16383];

  int checks = 0;
  int failures = 0;

  dmem_access_ctrl #(.ADDR_W(14)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Drives one request and records latency, response and memory activity.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rdata,
                        output int we_pulses, output int we_cycle,
                        output logic [31:0] we_data, output logic [13:0] issue_addr);
    lat = -1; err = 1'b0; rdata = 32'h0; we_pulses = 0; we_cycle = -1;
    we_data = 32'h0; issue_addr = 14'h0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 1) issue_addr = mem_addr;
      if (mem_we) begin we_pulses++; we_cycle = c; we_data = mem_wdata; end
      if (resp_valid) begin lat = c; err = resp_err; rdata = resp_rdata; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 14'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if ({resp_err, resp_rdata} !== 33'h0) begin failures++; $display("FAIL reset_resp got=%b/%h exp=0/0", resp_err, resp_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_word_access();
    int lat, wp, wc; logic err; logic [31:0] rd, wdat; logic [13:0] ia;
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, lat, err, rd, wp, wc, wdat, ia);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL sw_resp got=%b/%h exp=0/0", err, rd); end
    checks++; if (wp !== 1 || wc !== 1) begin failures++; $display("FAIL sw_we pulses=%0d cycle=%0d exp=1/1", wp, wc); end
    checks++; if (ia !== 14'd4 || wdat !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_port addr=%h data=%h exp=4/deadbeef", ia, wdat); end
    checks++; if (ram[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_ram got=%h exp=deadbeef", ram[4]); end
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, lat, err, rd, wp, wc, wdat, ia);
    checks++; if (lat !== 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin failures++; $display("FAIL lw_data got=%h err=%b exp=deadbeef/0", rd, err); end
    checks++; if (wp !== 0) begin failures++; $display("FAIL lw_no_we got=%0d exp=0", wp); end
  endtask

  task automatic test_subword_store();
    int lat, wp, wc; logic err; logic [31:0] rd, wdat; logic [13:0] ia;
    ram[4] = 32'h11223344;
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'hFFFFFFAA, lat, err, rd, wp, wc, wdat, ia);
    checks++; if (wp !== 1 || wc !== 3) begin failures++; $display("FAIL sb_we pulses=%0d cycle=%0d exp=1/3", wp, wc); end
    checks++; if (wdat !== 32'h11AA3344) begin failures++; $display("FAIL sb_wdata got=%h exp=11aa3344", wdat); end
    checks++; if (lat !== 4 || err !== 1'b0) begin failures++; $display("FAIL sb_resp lat=%0d err=%b exp=4/0", lat, err); end
    checks++; if (ram[4] !== 32'h11AA3344) begin failures++; $display("FAIL sb_ram got=%h exp=11aa3344", ram[4]); end
    ram[5] = 32'hAABBCCDD;
    do_req(1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'h1234ABCD, lat, err, rd, wp, wc, wdat, ia);
    checks++; if (ram[5] !== 32'hABCDCCDD || lat !== 4) begin failures++; $display("FAIL sh_ram got=%h lat=%0d exp=abcdccdd/4", ram[5], lat); end
    ram[5] = 32'hAABBCCDD;
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0017, 32'h0000_0055, lat, err, rd, wp, wc, wdat, ia);
    checks++; if (ram[5] !== 32'h55BBCCDD) begin failures++; $display("FAIL sb3_ram got=%h exp=55bbccdd", ram[5]); end
  endtask

  task automatic test_load_extend();
    logic [1:0]  sz  [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    logic        un  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad  [6] = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h10, 32'h11};
    logic [31:0] exv [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000,
                             32'h00008000, 32'h00007F80, 32'h0000007F};
    int lat, wp, wc; logic err; logic [31:0] rd, wdat; logic [13:0] ia;
    ram[4] = 32'h80007F80;
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, err, rd, wp, wc, wdat, ia);
      checks++;
      if (rd !== exv[i] || lat !== 3 || err !== 1'b0) begin
        failures++;
        $display("FAIL load_ext_%0d got=%h lat=%0d err=%b exp=%h/3/0", i, rd, lat, err, exv[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [1:0]  sz [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] ad [3] = '{32'h13, 32'h12, 32'h10};
    int lat, wp, wc; logic err; logic [31:0] rd, wdat; logic [13:0] ia;
    ram[4] = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      do_req(i == 2, sz[i], 1'b0, ad[i], 32'hFFFFFFFF, lat, err, rd, wp, wc, wdat, ia);
      checks++;
      if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wp !== 0) begin
        failures++;
        $display("FAIL err_%0d lat=%0d err=%b rdata=%h we=%0d exp=1/1/0/0", i, lat, err, rd, wp);
      end
    end
    checks++; if (ram[4] !== 32'h0BADF00D) begin failures++; $display("FAIL err_ram got=%h exp=0badf00d", ram[4]); end
  endtask

  task automatic test_reset_mid();
    int bad_we = 0, bad_resp = 0;
    ram[5] = 32'h55667788;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h16; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (mem_we) bad_we++;
      if (resp_valid) bad_resp++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL midrst_state ready=%b we=%b exp=1/0", req_ready, mem_we); end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (mem_we) bad_we++;
      if (resp_valid) bad_resp++;
    end
    checks++; if (bad_we !== 0 || bad_resp !== 0) begin failures++; $display("FAIL midrst_activity we=%0d resp=%0d exp=0/0", bad_we, bad_resp); end
    checks++; if (ram[5] !== 32'h55667788) begin failures++; $display("FAIL midrst_ram got=%h exp=55667788", ram[5]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exv [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    int accepts = 0, resps = 0, busy = 0;
    logic ready_now;
    for (int i = 0; i < 4; i++) ram[8 + i] = exv[i];
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20;
    ready_now = req_ready;
    for (int c = 0; c < 40 && resps < 4; c++) begin
      @(posedge clk); #1;
      if (ready_now && req_valid) begin
        accepts++;
        if (accepts < 4) req_addr = 32'h20 + 32'(4 * accepts);
        else req_valid = 1'b0;
      end
      ready_now = req_ready;
      if (!ready_now) busy++;
      if (resp_valid) begin
        checks++;
        if (resp_rdata !== exv[resps]) begin failures++; $display("FAIL b2b_data_%0d got=%h exp=%h", resps, resp_rdata, exv[resps]); end
        resps++;
      end
    end
    req_valid = 1'b0;
    checks++; if (resps !== 4 || accepts !== 4) begin failures++; $display("FAIL b2b_count resps=%0d accepts=%0d exp=4/4", resps, accepts); end
    checks++; if (busy !== 12) begin failures++; $display("FAIL b2b_busy got=%0d exp=12", busy); end
  endtask

  task automatic test_addr_wrap();
    int lat, wp, wc; logic err; logic [31:0] rd, wdat; logic [13:0] ia;
    ram[4] = 32'hCAFEF00D;
    do_req(1'b0, 2'b10, 1'b0, 32'h0001_0010, 32'h0, lat, err, rd, wp, wc, wdat, ia);
    checks++; if (ia !== 14'd4) begin failures++; $display("FAIL wrap_addr got=%h exp=4", ia); end
    checks++; if (rd !== 32'hCAFEF00D || lat !== 3) begin failures++; $display("FAIL wrap_data got=%h lat=%0d exp=cafef00d/3", rd, lat); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    test_reset();
    test_word_access();
    test_subword_store();
    test_load_extend();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_addr_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator-side controller that sits between the CPU execute/memory stage and the data memory.
- Accepts byte, halfword and word load/store requests from the pipeline over a valid/ready handshake.
- Drives the word-wide synchronous data RAM port:
  - word stores are written directly;
  - sub-word stores use read-modify-write;
  - loads are sign- or zero-extended before being returned on a one-cycle response strobe.

Parameters:
- ADDR_W, 14, width of word index driven to the RAM (word index = req_addr[ADDR_W+1:2]).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion strobe
- resp_err  out  1  qualifies resp_valid: misaligned/reserved request, no memory access made
- resp_rdata  out  32  extended load data (0 for stores and errors)
- mem_addr  out  ADDR_W  RAM word address
- mem_we  out  1  RAM write enable
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid one cycle after mem_addr is presented

Behaviour:
- Reset (synchronous): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_addr=0; mem_wdata=0; latched request cleared.
- Reset mid-operation:
  - abandons the request with no response;
  - mem_we is 0 from the cycle after the reset edge;
  - a sub-word store reset before WRITE never writes.
- Handshake:
  - accept when req_valid && req_ready, at cycle 0;
  - latch write/size/unsigned/addr/wdata;
  - req_valid while busy is ignored;
  - req_ready rises again the cycle after resp_valid, so back-to-back requests have one idle gap minimum.
- Memory outputs are decoded from registered state and latched fields only; there is no combinational path from req_* to mem_*.
- Error check at accept:
  - size=11 is an error;
  - size=01 with addr[0]=1 is an error;
  - size=10 with addr[1:0]!=0 is an error;
  - on error: go to RESP with resp_err=1, no RAM access.
- States:
  - IDLE: req_ready=1. On accept: error → RESP(err), else → ISSUE.
  - ISSUE (cycle 1): mem_addr=word index.
    - Word store: mem_we=1, mem_wdata=wdata, → RESP.
    - Otherwise: mem_we=0, → WAIT.
  - WAIT (cycle 2): capture mem_rdata into rd_reg.
    - Load → RESP with extended data.
    - Sub-word store → WRITE.
  - WRITE (cycle 3): mem_addr unchanged, mem_we=1, mem_wdata=rd_reg with the target lane replaced, → RESP.
  - RESP: resp_valid=1 for exactly one cycle, → IDLE. resp_err, resp_rdata hold until the next response; they are meaningful only with resp_valid.
- Latency (accept cycle 0 → resp_valid cycle):
  - error: 1
  - word store: 2
  - load: 3
  - sub-word store: 4
- Lanes are little-endian:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane];
  - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Byte store uses wdata[7:0]; half store uses wdata[15:0]; the other RAM bytes are preserved exactly.
- Load extension:
  - byte: bit 7 replicated, or zeros if unsigned;
  - half: bit 15 replicated, or zeros if unsigned;
  - word: unchanged; req_unsigned is ignored.
- req_addr bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
- mem_we is never high outside ISSUE(word store) and WRITE.

Test Plan:
- Reset, then word store addr 0x0000_0010 data 0xDEADBEEF → mem_we=1 at cycle 1 with mem_addr=4, resp_valid at cycle 2, resp_err=0; word load of the same address → resp_rdata=0xDEADBEEF at cycle 3.
- RAM word 4 = 0x11223344; byte store addr 0x12 data 0xFFFFFFAA → single mem_we pulse at cycle 3 with mem_wdata=0x11AA3344, resp at cycle 4.
- RAM word 4 = 0x8000_7F80:
  - lb 0x10 → 0xFFFFFF80
  - lbu 0x10 → 0x00000080
  - lh 0x12 → 0xFFFF8000
  - lhu 0x12 → 0x00008000
  - lh 0x10 → 0x00007F80
- Misaligned and reserved requests:
  - lh 0x13 → resp_valid with resp_err=1 at cycle 1, mem_we never asserted, RAM unchanged;
  - lw 0x12 → same;
  - size=11 → same.
- Issue a half store to 0x16, assert rst at cycle 2 (WAIT) → no resp_valid, mem_we stays 0, RAM word 5 unchanged, req_ready=1 the cycle after reset.
- Hold req_valid high with a stream of 4 loads → exactly 4 resp_valid pulses, req_ready low while busy, no request dropped or duplicated.
- Address wrap (ADDR_W=14): word load addr 0x0001_0010 → mem_addr=4.
